// File: rtl/rv_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_e  : arbiter FSM states
//   *_DEF        : default address width, data width and memory timeout
package rv_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TMO_CYC_DEF = 255;

  // I_DRAIN: a flushed fetch is still outstanding at the memory and must be
  // completed (or timed out) before the port can be reused.
  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DRAIN
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
//   clk, reset                       : clock, synchronous active-high reset
//   if_req/if_addr/if_flush          : fetch request, address, fetch kill
//   if_rdata/if_valid/if_stall       : fetch data, done pulse, stall
//   dm_req/we/addr/wdata/be          : data-stage load/store request
//   dm_rdata/dm_valid/dm_stall       : load data, done pulse, stall
//   mem_req/we/addr/wdata/be         : registered request to memory
//   mem_ready/mem_rdata              : memory completion and read data
//   mem_err                          : sticky memory timeout flag
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  arb_state_e        state_q, state_d;
  logic              last_i_q, last_i_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic if_go, dm_go, grant_d, grant_i;

  // A requester holds its request through the valid cycle, so a request seen
  // alongside its own valid pulse is the completed one and must not regrant.
  assign if_go   = if_req & ~if_flush & ~if_valid_q;
  assign dm_go   = dm_req & ~dm_valid_q;
  assign grant_d = dm_go & (~if_go | last_i_q);
  assign grant_i = if_go & ~grant_d;

  always_comb begin
    state_d     = state_q;
    last_i_d    = last_i_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_BUSY;
          last_i_d    = 1'b0;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
        end else if (grant_i) begin
          state_d     = I_BUSY;
          last_i_d    = 1'b1;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end
      I_BUSY, D_BUSY, I_DRAIN: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          // A flush landing on the completion cycle discards the data.
          if (state_q == I_BUSY && !if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else if (state_q == D_BUSY) begin
            dm_valid_d = 1'b1;
            dm_rdata_d = mem_we_q ? '0 : mem_rdata;
          end
        end else if (wait_q == TMO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
          if (state_q == I_BUSY && if_flush) begin
            state_d = I_DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b1;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_i_q    <= last_i_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_err   = err_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width.
REQ-002 Parameter: DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter: TMO_CYC, default 255, max cycles waiting for mem_ready before error.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 if_req / if_addr  in  1 / ADDR_W  fetch read request and address; held stable until if_valid.
REQ-007 if_flush  in  1  kill in-flight or pending fetch.
REQ-008 if_rdata / if_valid / if_stall  out  DATA_W / 1 / 1  fetch data, 1-cycle done pulse, stall to IF stage.
REQ-009 dm_req / dm_we / dm_addr / dm_wdata / dm_be  in  1 / 1 / ADDR_W / DATA_W / DATA_W/8  data-stage access, held until dm_valid.
REQ-010 dm_rdata / dm_valid / dm_stall  out  DATA_W / 1 / 1  load data, done pulse, stall to MEM stage.
REQ-011 mem_req / mem_we / mem_addr / mem_wdata / mem_be  out  1 / 1 / ADDR_W / DATA_W / DATA_W/8  unified single-port memory request.
REQ-012 mem_ready / mem_rdata  in  1 / DATA_W  memory completion and read data.
REQ-013 mem_err  out  1  sticky timeout flag.

Function
REQ-014 FSM states: IDLE, I_BUSY, D_BUSY, I_DRAIN.
REQ-015 IDLE, dm_req only -> D_BUSY; if_req only (if_flush low) -> I_BUSY; neither -> IDLE.
REQ-016 IDLE, both pending -> grant side not granted last; last-grant register resets to "I" so D wins first contest.
REQ-017 On grant, request fields registered; mem_req=1 from next cycle, fields stable, until mem_ready sampled high.
REQ-018 mem_ready high in I_BUSY -> if_rdata<=mem_rdata, if_valid=1 next cycle, state IDLE.
REQ-019 mem_ready high in D_BUSY -> dm_valid=1 next cycle; dm_rdata<=mem_rdata for loads, 0 for stores; state IDLE.
REQ-020 Minimum latency request-to-valid with zero-wait memory: 2 cycles; back-to-back grants: one every 3 cycles.
REQ-021 if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid (combinational).
REQ-022 if_flush in I_BUSY -> I_DRAIN; I_DRAIN waits mem_ready, then IDLE, no if_valid.
REQ-023 if_flush in I_DRAIN or D_BUSY: no effect; if_flush with if_req in IDLE: fetch not granted that cycle.
REQ-024 mem_ready ignored in IDLE.
REQ-025 8-bit-min wait counter clears on grant, increments each busy/drain cycle with mem_ready low; reaching TMO_CYC sets mem_err, drops mem_req, returns IDLE, no valid pulse.
REQ-026 mem_err cleared only by reset.

Reset
REQ-027 Reset: state IDLE, last-grant "I", wait counter 0, mem_req 0, mem_we 0, mem_addr/wdata/be 0, if_valid/dm_valid 0, if_rdata/dm_rdata 0, mem_err 0.
REQ-028 Reset mid-transaction: abort, mem_req low next cycle, no valid pulse; memory abandons request.

Structure
REQ-029 Package rv_mem_pkg: FSM state enum, ADDR_W/DATA_W defaults, TMO_CYC default.
REQ-030 Single module; no sub-module required.

Verification
REQ-031 if_req addr 0x0000_0010, mem_ready=1 one cycle after mem_req, mem_rdata 0x0050_0093 -> if_valid pulse at request+2, if_rdata 0x0050_0093, if_stall high 2 cycles.
REQ-032 if_req and dm_req (load 0x100) same cycle after reset -> D granted first, dm_valid; I granted next, if_valid; mem_addr sequence 0x100 then fetch address.
REQ-033 Store dm_we=1 addr 0x200 wdata 0xDEAD_BEEF be 0xF, mem_ready after 3 wait cycles -> mem fields stable 4 cycles, dm_valid pulse, dm_rdata 0.
REQ-034 Fetch granted, if_flush one cycle later, mem_ready 2 cycles after -> I_DRAIN, no if_valid, next fetch granted after drain.
REQ-035 mem_ready held low, TMO_CYC=8 -> mem_err=1 after 8 wait cycles, mem_req low, stays set until reset.
REQ-036 reset asserted during D_BUSY -> next cycle mem_req 0, all outputs at reset values, no dm_valid.
